// File: rtl/ofm_writeback_packer.sv
// ofm_writeback_packer
// Captures 16 per-PE OFM bytes when the PE cluster's valid vector is all ones,
// buffers the 128-bit groups in a small FIFO and streams each group as four
// 32-bit words into the OFM BRAM write port. Addresses auto-increment from
// addr_base. done pulses once TOTAL_WORDS words have been accepted.
// Optional macro OFM_RELU_EN: bytes with bit7 set are zeroed at capture.
//
// state | meaning
// IDLE  | waiting for start, valid ignored
// RUN   | capturing groups and draining the FIFO to BRAM
module ofm_writeback_packer #(
  parameter int ADDR_W      = 32,
  parameter int TOTAL_WORDS = 100352,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             addr_base,
  input  logic [15:0]                   valid,
  input  logic [7:0]                    OFM_0,
  input  logic [7:0]                    OFM_1,
  input  logic [7:0]                    OFM_2,
  input  logic [7:0]                    OFM_3,
  input  logic [7:0]                    OFM_4,
  input  logic [7:0]                    OFM_5,
  input  logic [7:0]                    OFM_6,
  input  logic [7:0]                    OFM_7,
  input  logic [7:0]                    OFM_8,
  input  logic [7:0]                    OFM_9,
  input  logic [7:0]                    OFM_10,
  input  logic [7:0]                    OFM_11,
  input  logic [7:0]                    OFM_12,
  input  logic [7:0]                    OFM_13,
  input  logic [7:0]                    OFM_14,
  input  logic [7:0]                    OFM_15,
  input  logic                          wr_ready,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [31:0]                   wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic                          partial_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = $clog2(TOTAL_WORDS + 1);
  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(TOTAL_WORDS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [127:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [1:0]         k_q;
  logic [WC_W-1:0]    wc_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               done_q, overflow_q, partial_q;

  logic [7:0]         ofm_b [16];
  logic [127:0]       group_in;
  logic [127:0]       head;
  logic               running, accept, last_accept, pop, push_req, push, drop, partial;

  assign ofm_b[0]  = OFM_0;
  assign ofm_b[1]  = OFM_1;
  assign ofm_b[2]  = OFM_2;
  assign ofm_b[3]  = OFM_3;
  assign ofm_b[4]  = OFM_4;
  assign ofm_b[5]  = OFM_5;
  assign ofm_b[6]  = OFM_6;
  assign ofm_b[7]  = OFM_7;
  assign ofm_b[8]  = OFM_8;
  assign ofm_b[9]  = OFM_9;
  assign ofm_b[10] = OFM_10;
  assign ofm_b[11] = OFM_11;
  assign ofm_b[12] = OFM_12;
  assign ofm_b[13] = OFM_13;
  assign ofm_b[14] = OFM_14;
  assign ofm_b[15] = OFM_15;

  // Assemble the group with PE0 in the lowest byte, optionally clamping negatives.
  always_comb begin
    group_in = '0;
    for (int i = 0; i < 16; i++) begin
`ifdef OFM_RELU_EN
      group_in[8*i +: 8] = ofm_b[i][7] ? 8'h00 : ofm_b[i];
`else
      group_in[8*i +: 8] = ofm_b[i];
`endif
    end
  end

  // Handshake and FIFO control; start takes priority over everything in RUN.
  assign running     = (state_q == S_RUN);
  assign wr_en       = running && (count_q != '0);
  assign accept      = wr_en && wr_ready && !start;
  assign last_accept = accept && (wc_q == LAST_WORD);
  assign pop         = accept && (k_q == 2'd3);
  assign push_req    = running && !start && (valid == 16'hFFFF);
  assign push        = push_req && ((count_q < DEPTH_C) || pop);
  assign drop        = push_req && !push;
  assign partial     = running && !start && (valid != 16'h0000) && (valid != 16'hFFFF);

  assign head        = mem[rd_ptr_q];
  assign wr_data     = head[{k_q, 5'd0} +: 32];
  assign wr_addr     = addr_q;
  assign busy        = running;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign partial_err = partial_q;
  assign fifo_count  = count_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (start)            state_d = S_RUN;
        else if (last_accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Group FIFO with word index; flushed on start and when the layer completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      k_q      <= '0;
    end else if (start || last_accept) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      k_q      <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= group_in;
        wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
      end
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (accept) k_q      <= k_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Address, word counter, done pulse and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      wc_q       <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      partial_q  <= 1'b0;
    end else if (start) begin
      addr_q     <= addr_base;
      wc_q       <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      partial_q  <= 1'b0;
    end else begin
      done_q <= last_accept;
      if (accept) begin
        addr_q <= addr_q + ADDR_W'(1);
        wc_q   <= last_accept ? '0 : wc_q + WC_W'(1);
      end
      if (drop)    overflow_q <= 1'b1;
      if (partial) partial_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Randomized and directed bench for ofm_writeback_packer against a
// word-queue reference model.
module tb_ofm_writeback_packer;
  localparam int ADDR_W = 32;
  localparam int TOTAL  = 8;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, wr_ready;
  logic [31:0] addr_base;
  logic [15:0] valid;
  logic [7:0]  ofm [16];
  logic        wr_en, busy, done, overflow, partial_err;
  logic [31:0] wr_addr, wr_data;
  logic [1:0]  fifo_count;

  ofm_writeback_packer #(.ADDR_W(ADDR_W), .TOTAL_WORDS(TOTAL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .addr_base(addr_base), .valid(valid),
    .OFM_0(ofm[0]), .OFM_1(ofm[1]), .OFM_2(ofm[2]), .OFM_3(ofm[3]),
    .OFM_4(ofm[4]), .OFM_5(ofm[5]), .OFM_6(ofm[6]), .OFM_7(ofm[7]),
    .OFM_8(ofm[8]), .OFM_9(ofm[9]), .OFM_10(ofm[10]), .OFM_11(ofm[11]),
    .OFM_12(ofm[12]), .OFM_13(ofm[13]), .OFM_14(ofm[14]), .OFM_15(ofm[15]),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow), .partial_err(partial_err),
    .fifo_count(fifo_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic        m_run = 1'b0;
  logic [31:0] m_q[$];
  logic [31:0] m_addr = '0;
  int          m_acc = 0;
  logic        m_done = 1'b0, m_ovf = 1'b0, m_perr = 1'b0;

  logic [63:0] wlog[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [127:0] g, input int k);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      b = g[8*(4*k+j) +: 8];
`ifdef OFM_RELU_EN
      if (b[7]) b = 8'h00;
`endif
      w[8*j +: 8] = b;
    end
    return w;
  endfunction

  function automatic logic [127:0] ramp_group(input logic [7:0] base);
    logic [127:0] g;
    for (int i = 0; i < 16; i++) g[8*i +: 8] = base + 8'(i);
    return g;
  endfunction

  task automatic compare_model();
    logic exp_en;
    exp_en = m_run && (m_q.size() > 0);
    check_val("wr_en", 64'(wr_en), 64'(exp_en));
    check_val("busy", 64'(busy), 64'(m_run));
    check_val("done", 64'(done), 64'(m_done));
    check_val("overflow", 64'(overflow), 64'(m_ovf));
    check_val("partial_err", 64'(partial_err), 64'(m_perr));
    check_val("fifo_count", 64'(fifo_count), 64'((m_q.size() + 3) / 4));
    if (exp_en) begin
      check_val("wr_addr", 64'(wr_addr), 64'(m_addr));
      check_val("wr_data", 64'(wr_data), 64'(m_q[0]));
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model, cross the edge.
  task automatic step(input logic st, input logic [31:0] ab, input logic [15:0] v,
                      input logic [127:0] g, input logic rdy);
    logic acc, pop;
    int   groups;
    compare_model();
    if (wr_en && rdy && !st) wlog.push_back({wr_addr, wr_data});
    start = st; addr_base = ab; valid = v; wr_ready = rdy;
    for (int i = 0; i < 16; i++) ofm[i] = g[8*i +: 8];
    acc = m_run && (m_q.size() > 0) && rdy;
    if (st) begin
      m_run = 1'b1; m_q.delete(); m_addr = ab; m_acc = 0;
      m_done = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
    end else if (m_run) begin
      groups = (m_q.size() + 3) / 4;
      pop = acc && (m_q.size() % 4 == 1);
      m_done = 1'b0;
      if (acc) begin
        void'(m_q.pop_front());
        m_addr = m_addr + 32'd1;
        m_acc++;
      end
      if (v == 16'hFFFF) begin
        if (groups < DEPTH || pop) for (int k = 0; k < 4; k++) m_q.push_back(model_word(g, k));
        else m_ovf = 1'b1;
      end else if (v != 16'h0000) begin
        m_perr = 1'b1;
      end
      if (acc && m_acc == TOTAL) begin
        m_run = 1'b0; m_q.delete(); m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 16'h0, 128'h0, rdy);
  endtask

  logic [31:0]  t1_exp [8];
  logic [127:0] g2;
  logic [31:0]  r6 [4];

  initial begin
    t1_exp = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
               32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    reset_n = 1'b0; start = 1'b0; addr_base = '0; valid = '0; wr_ready = 1'b0;
    for (int i = 0; i < 16; i++) ofm[i] = '0;
    repeat (3) @(negedge clk);
    compare_model();
    check_val("rst_wr_addr", 64'(wr_addr), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: two groups, continuous ready
    wlog.delete();
    step(1'b1, 32'h100, 16'h0, 128'h0, 1'b1);
`ifndef OFM_RELU_EN
    step(1'b0, 32'h0, 16'hFFFF, ramp_group(8'h00), 1'b1);
    step(1'b0, 32'h0, 16'hFFFF, ramp_group(8'h10), 1'b1);
    idle(10, 1'b1);
    check_val("t1_nwords", 64'(wlog.size()), 64'd8);
    for (int i = 0; i < 8 && i < wlog.size(); i++)
      check_val("t1_word", wlog[i], {32'h100 + 32'(i), t1_exp[i]});
`else
    step(1'b0, 32'h0, 16'hFFFF, ramp_group(8'h00), 1'b1);
    step(1'b0, 32'h0, 16'hFFFF, ramp_group(8'h10), 1'b1);
    idle(10, 1'b1);
    check_val("t1_nwords", 64'(wlog.size()), 64'd8);
`endif
    check_val("t1_busy", 64'(busy), 64'h0);

    // 2: back-pressure with overflow
    wlog.delete();
    step(1'b1, 32'h500, 16'h0, 128'h0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    idle(7, 1'b0);
    check_val("t2_count", 64'(fifo_count), 64'd2);
    check_val("t2_ovf", 64'(overflow), 64'd1);
    idle(12, 1'b1);
    check_val("t2_nwords", 64'(wlog.size()), 64'd8);
    for (int i = 0; i < wlog.size(); i++)
      check_val("t2_addr", 64'(wlog[i][63:32]), 64'(32'h500 + 32'(i)));

    // 3: partial valid
    wlog.delete();
    step(1'b1, 32'h0, 16'h0, 128'h0, 1'b1);
    step(1'b0, 32'h0, 16'h00FF, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    idle(3, 1'b1);
    check_val("t3_perr", 64'(partial_err), 64'd1);
    check_val("t3_count", 64'(fifo_count), 64'd0);
    check_val("t3_nwords", 64'(wlog.size()), 64'd0);

    // 4: toggling ready
    wlog.delete();
    step(1'b1, 32'h40, 16'h0, 128'h0, 1'b1);
    step(1'b0, 32'h0, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 16'h0, 128'h0, (i % 2) == 0);
    check_val("t4_nwords", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < wlog.size(); i++)
      check_val("t4_addr", 64'(wlog[i][63:32]), 64'(32'h40 + 32'(i)));

    // 5: restart mid-group
    wlog.delete();
    step(1'b1, 32'h300, 16'h0, 128'h0, 1'b1);
    step(1'b0, 32'h0, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 32'h200, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    g2 = {$urandom, $urandom, $urandom, $urandom};
    step(1'b0, 32'h0, 16'hFFFF, g2, 1'b1);
    idle(6, 1'b1);
    check_val("t5_nwords", 64'(wlog.size()), 64'd6);
    for (int i = 2; i < 6 && i < wlog.size(); i++)
      check_val("t5_word", wlog[i], {32'h200 + 32'(i - 2), model_word(g2, i - 2)});

    // 6: negative bytes
    wlog.delete();
`ifdef OFM_RELU_EN
    r6 = '{32'h0, 32'h0, 32'h0, 32'h0};
`else
    r6 = '{32'h83828180, 32'h87868584, 32'h8B8A8988, 32'h8F8E8D8C};
`endif
    step(1'b1, 32'h0, 16'h0, 128'h0, 1'b1);
    step(1'b0, 32'h0, 16'hFFFF, ramp_group(8'h80), 1'b1);
    idle(5, 1'b1);
    check_val("t6_nwords", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      check_val("t6_word", 64'(wlog[i][31:0]), 64'(r6[i]));

    // random phase
    for (int c = 0; c < 3000; c++) begin
      logic        st, rdy;
      logic [15:0] v;
      logic [31:0] ab;
      int          r;
      st = (!m_run && $urandom_range(0, 7) == 0) || ($urandom_range(0, 149) == 0);
      ab = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
      r  = $urandom_range(0, 9);
      if (r < 5)      v = 16'hFFFF;
      else if (r < 8) v = 16'h0000;
      else            v = 16'($urandom_range(1, 16'hFFFE));
      rdy = ($urandom_range(0, 3) != 0);
      step(st, ab, v, {$urandom, $urandom, $urandom, $urandom}, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ofm_writeback_packer.md
Name: ofm_writeback_packer

Overview:
- Sits directly downstream of the MB_CONV PE-cluster subtop.
- Captures the 16 per-PE 8-bit OFM bytes whenever the cluster's valid vector fires, buffers them, packs them into four 32-bit words, and streams those words into the OFM BRAM write port with auto-incrementing addresses.
- Signals completion after a programmed number of words has been written.

Parameters:
- ADDR_W, 32, width of the OFM BRAM write address.
- TOTAL_WORDS, 100352, words per layer (56*56*128/4); done fires after this many accepted writes.
- FIFO_DEPTH, 2, number of 16-byte output groups buffered; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; loads addr_base, clears counters and FIFO, enters RUN
- addr_base  in  ADDR_W  first write address, sampled on start
- valid  in  16  per-PE valid from the PE cluster
- OFM_0 .. OFM_15  in  8 each  per-PE output bytes
- wr_ready  in  1  BRAM/arbiter accepts a write this cycle
- wr_en  out  1  write request
- wr_addr  out  ADDR_W  write address
- wr_data  out  32  packed write data
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last word is accepted
- overflow  out  1  sticky; a group was dropped because the FIFO was full
- partial_err  out  1  sticky; valid was nonzero but not 16'hFFFF
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied groups

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, FIFO empty, counters 0, wr_addr 0.
- States:
  - IDLE: valid is ignored; start -> RUN.
  - RUN: captures groups and drains the FIFO; when the accepted word count reaches TOTAL_WORDS, done is pulsed and the state returns to IDLE.
- Capture (RUN only):
  - valid==16'hFFFF at a rising edge pushes {OFM_15..OFM_0} as one 128-bit group.
  - valid!=0 and !=16'hFFFF pushes nothing and sets partial_err.
- Packing:
  - Word k (k=0..3) = {OFM_(4k+3), OFM_(4k+2), OFM_(4k+1), OFM_(4k)}, i.e. the lowest PE index goes in the LSB byte.
  - Words are issued k=0 first.
- Latency: a group captured at edge N gives wr_en=1 with word 0 in the cycle after edge N (registered outputs). With the FIFO empty and wr_ready held high, the four words occupy four consecutive cycles.
- Handshake:
  - A word is accepted when wr_en && wr_ready.
  - wr_en, wr_addr and wr_data stay stable while wr_ready=0.
  - wr_addr increments by 1 per accepted word.
  - The group is popped when word 3 is accepted.
- FIFO full:
  - A push while full is accepted only if a pop occurs on the same edge.
  - Otherwise the group is dropped and overflow is set; count is unchanged.
- Simultaneous push and pop: count is unchanged, data ordering is preserved.
- Address: 32-bit wrap-around at 2^ADDR_W, no saturation.
- Done:
  - Asserted for exactly one cycle, the cycle after the final accept.
  - wr_en is 0 that cycle.
  - Leftover FIFO contents are discarded on entering IDLE.
- start in RUN (restart mid-operation):
  - Aborts the current operation, flushes the FIFO, reloads addr_base and clears the word counter.
  - A valid on the same edge is ignored.
  - overflow and partial_err are cleared only by start or reset.
- start in IDLE with valid on the same edge: valid is ignored.

Optional Feature:
- Macro OFM_RELU_EN.
  - Defined: each byte is treated as signed, and any byte with bit7=1 is replaced by 8'h00 at capture, before it enters the FIFO.
  - Undefined: bytes pass through unmodified.
- Latency is identical in both cases.

Test Plan:
1. Reset, start with addr_base=0x100, TOTAL_WORDS=8; two valid=FFFF groups with OFM_i=i (first) and 0x10+i (second); wr_ready=1 -> writes 0x100:0x03020100, 0x101:0x07060504, 0x102:0x0B0A0908, 0x103:0x0F0E0D0C, 0x104:0x13121110 .. 0x107:0x1F1E1D1C; done pulses one cycle after the 0x107 accept; busy drops.
2. wr_ready=0 held for 10 cycles while 3 groups arrive back-to-back -> first 2 groups buffered (fifo_count=2), third dropped, overflow=1; after release, 8 words written with addresses contiguous.
3. valid=16'h00FF for one cycle -> no write, partial_err=1, fifo_count unchanged.
4. wr_ready toggling 1,0,1,0 -> wr_addr and wr_data held during the 0 cycles; each word is written exactly once.
5. Restart: start pulse mid-group (after word 1 accepted), addr_base=0x200 -> no further writes from the old group; the next group writes to 0x200..0x203.
6. OFM_RELU_EN defined, OFM_i=0x80|i -> all four words 0x00000000. Undefined -> 0x83828180 first word.
